// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the iteration-counter sizing helper.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  // Counter must hold 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: yields |x| at operand capture and
// restores the result sign in the FIX state.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? -value : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide on unsigned magnitudes, with sign correction at the end.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  mdu_state_t         state, state_next;
  logic [CW-1:0]      count;
  // Upper half: multiply partial product / divide remainder.
  // Lower half: multiplier being shifted out / dividend becoming quotient.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, res_neg, rem_neg, dbz;

  logic op_md, op_signed, op_div, launch;
  assign op_md     = (Op == MDU_MULT) || (Op == MDU_MULTU) ||
                     (Op == MDU_DIV)  || (Op == MDU_DIVU);
  assign op_signed = (Op == MDU_MULT) || (Op == MDU_DIV);
  assign op_div    = (Op == MDU_DIV)  || (Op == MDU_DIVU);
  assign launch    = (state == ST_IDLE) && Start && op_md;

  logic [WIDTH-1:0] abs_a, abs_b;
  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .value(A), .negate(op_signed & A[WIDTH-1]), .result(abs_a)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .value(B), .negate(op_signed & B[WIDTH-1]), .result(abs_b)
  );

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;
  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value(acc), .negate(res_neg), .result(prod_fixed)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .value(acc[WIDTH-1:0]), .negate(res_neg), .result(quot_fixed)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .value(acc[2*WIDTH-1:WIDTH]), .negate(rem_neg), .result(rem_fixed)
  );

  // One shift-add multiply step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step; the subtraction only commits when it fits.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_step;
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;
  assign div_step  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ge};

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE: if (launch) state_next = (op_div && (B == '0)) ? ST_FIX : ST_CALC;
      ST_CALC: if (count == LAST) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values and simulation matches the synthesized flops.
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  assign Busy = (state != ST_IDLE);

  always_ff @(posedge Clk) begin
    // NOTE: datapath registers are reset too, so an aborted operation leaves
    // no stale operands behind and every output starts from a known value.
    if (Reset) begin
      count     <= '0;
      acc       <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      dbz       <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done      <= (state == ST_FIX);
      DivByZero <= (state == ST_FIX) && dbz;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            acc     <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
            opnd    <= op_div ? abs_b : abs_a;
            is_div  <= op_div;
            res_neg <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            rem_neg <= op_signed & A[WIDTH-1];
            dbz     <= op_div && (B == '0);
            count   <= '0;
          end else if (Start && (Op == MDU_MTHI)) begin
            Hi <= A;
          end else if (Start && (Op == MDU_MTLO)) begin
            Lo <= A;
          end
        end
        ST_CALC: begin
          acc   <= is_div ? div_step : mul_step;
          count <= count + CW'(1);
        end
        ST_FIX: begin
          if (!dbz) begin
            if (is_div) begin
              Hi <= rem_fixed;
              Lo <= quot_fixed;
            end else begin
              {Hi, Lo} <= prod_fixed;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int WIDTH = 32;

  logic             Clk = 1'b0;
  logic             Reset, Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A, B;
  logic             Busy, Done, DivByZero;
  logic [WIDTH-1:0] Hi, Lo;

  int tests  = 0;
  int failed = 0;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a launch at the current negedge; returns at the next negedge (N0).
  task automatic launch_now(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; Op = MDU_MULT; A = '0; B = '0;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    launch_now(op, a, b);
  endtask

  // Counts Busy samples until Done is seen; bounded.
  task automatic wait_done(output int busy_cycles);
    int guard;
    guard = 0;
    busy_cycles = 0;
    while (Done !== 1'b1 && guard < 200) begin
      if (Busy) busy_cycles++;
      @(negedge Clk);
      guard++;
    end
    if (guard >= 200) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    launch(op, a, b);
    wait_done(n);
    check({tag, "_busy_cycles"}, n, 33);
    check({tag, "_hi"}, Hi, exp_hi);
    check({tag, "_lo"}, Lo, exp_lo);
    check({tag, "_dbz"}, DivByZero, 1'b0);
    check({tag, "_busy_at_done"}, Busy, 1'b0);
    @(negedge Clk);
    check({tag, "_done_pulse"}, Done, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    Reset = 1'b1; Start = 1'b0; Op = MDU_MULT; A = '0; B = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_dbz", DivByZero, 1'b0);
    check("rst_hi", Hi, 32'h0);
    check("rst_lo", Lo, 32'h0);

    run_op("mult_neg",    MDU_MULT,  32'hFFFFFFFE, 32'd3,       32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max",   MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg",     MDU_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",        MDU_DIVU,  32'd7,        32'd2,       32'd1,        32'd3);

    // Divide by zero: Hi/Lo keep 1/3, flags pulse one cycle after FIX.
    launch(MDU_DIVU, 32'd5, 32'd0);
    wait_done(n);
    check("dbz_busy_cycles", n, 1);
    check("dbz_flag", DivByZero, 1'b1);
    check("dbz_hi_kept", Hi, 32'd1);
    check("dbz_lo_kept", Lo, 32'd3);
    @(negedge Clk);
    check("dbz_done_pulse", Done, 1'b0);
    check("dbz_flag_pulse", DivByZero, 1'b0);

    run_op("div_ovf",     MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,       32'h80000000);
    run_op("div_pos_neg", MDU_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,       32'hFFFFFFF2);

    launch(MDU_MTHI, 32'h12345678, 32'd0);
    check("mthi_hi", Hi, 32'h12345678);
    check("mthi_lo_kept", Lo, 32'hFFFFFFF2);
    check("mthi_busy", Busy, 1'b0);
    check("mthi_done", Done, 1'b0);
    launch(MDU_MTLO, 32'hCAFEF00D, 32'd0);
    check("mtlo_lo", Lo, 32'hCAFEF00D);
    check("mtlo_hi_kept", Hi, 32'h12345678);

    // Starts while busy must not disturb the MULT in flight (5 * -4 = -20).
    launch(MDU_MULT, 32'd5, 32'hFFFFFFFC);
    repeat (4) @(negedge Clk);
    launch_now(MDU_MTHI, 32'hDEADBEEF, 32'd0);
    check("busy_mthi_ignored", Hi, 32'h12345678);
    check("busy_still", Busy, 1'b1);
    launch_now(MDU_DIVU, 32'd9, 32'd0);
    wait_done(n);
    check("busy_remaining_cycles", n, 27);
    check("busy_mult_hi", Hi, 32'hFFFFFFFF);
    check("busy_mult_lo", Lo, 32'hFFFFFFEC);
    check("busy_mult_dbz", DivByZero, 1'b0);

    // Launch in the Done cycle: 0x10000 * 0x10000 = 2^32.
    launch_now(MDU_MULTU, 32'h00010000, 32'h00010000);
    check("b2b_busy", Busy, 1'b1);
    wait_done(n);
    check("b2b_busy_cycles", n, 33);
    check("b2b_hi", Hi, 32'd1);
    check("b2b_lo", Lo, 32'd0);

    launch(3'd6, 32'h1111, 32'h2222);
    check("badop_busy", Busy, 1'b0);
    check("badop_hi", Hi, 32'd1);
    check("badop_lo", Lo, 32'd0);

    // Reset near iteration 10 of a DIVU, together with a competing MTHI.
    launch(MDU_DIVU, 32'hFFFFFFFF, 32'd3);
    repeat (9) @(negedge Clk);
    Reset = 1'b1; Start = 1'b1; Op = MDU_MTHI; A = 32'h55;
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0; Op = MDU_MULT; A = '0;
    check("rst_mid_busy", Busy, 1'b0);
    check("rst_mid_hi", Hi, 32'd0);
    check("rst_mid_lo", Lo, 32'd0);
    seen = 0;
    repeat (40) begin
      if (Done) seen++;
      @(negedge Clk);
    end
    check("rst_mid_no_done", seen, 0);

    run_op("multu_small", MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
